// File: rtl/main_button_poller.sv
// main_button_poller: Avalon-MM read master that polls a one-bit button PIO
// on a fixed period, debounces the sampled bit, and produces a debounced
// level, a one-cycle press strobe and a wrapping 16-bit press counter.
//
// Optional feature: define BUTTON_POLLER_RELEASE_EVT_EN to add the
// release_pulse output (one-cycle strobe on a debounced 1->0 transition).
//
// state | meaning
// IDLE  | dwell timer counts 0..POLL_DIV-1 while enabled, held at 0 otherwise
// REQ   | avm_read asserted, held until the slave drops waitrequest
// CAPT  | read data returns (latency 1), raw button level latched
// EVAL  | debounce update and press/release event generation
module main_button_poller #(
  parameter int POLL_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        pressed,
  output logic        press_pulse,
`ifdef BUTTON_POLLER_RELEASE_EVT_EN
  output logic [15:0] press_count,
  output logic        release_pulse
`else
  output logic [15:0] press_count
`endif
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_REQ  = 2'd1;
  localparam logic [1:0]  S_CAPT = 2'd2;
  localparam logic [1:0]  S_EVAL = 2'd3;

  localparam logic [15:0] TIMER_LAST = 16'(POLL_DIV - 1);
  localparam logic [7:0]  DEB_LAST   = 8'(DEBOUNCE_CNT - 1);
  localparam logic        ACT_LOW    = (ACTIVE_LOW != 0);

  logic [1:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        raw_q, raw_d;
  logic        abort_q, abort_d;
  logic        pressed_q, pressed_d;
  logic        press_pulse_q, press_pulse_d;
  logic [15:0] press_count_q, press_count_d;
  logic [7:0]  stable_cnt_q, stable_cnt_d;
`ifdef BUTTON_POLLER_RELEASE_EVT_EN
  logic        release_pulse_q, release_pulse_d;
`endif

  // Only bit 0 of the PIO data register carries the button.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:1];

  // Next-state logic: poll timer, read handshake, sample capture and debounce.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    raw_d         = raw_q;
    abort_d       = abort_q;
    pressed_d     = pressed_q;
    press_pulse_d = 1'b0;
    press_count_d = press_count_q;
    stable_cnt_d  = stable_cnt_q;
`ifdef BUTTON_POLLER_RELEASE_EVT_EN
    release_pulse_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (!enable) begin
          timer_d = 16'd0;
        end else if (timer_q == TIMER_LAST) begin
          timer_d = 16'd0;
          state_d = S_REQ;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_REQ: begin
        // The request is never withdrawn; a disable only marks the sample stale.
        if (!enable) abort_d = 1'b1;
        if (!avm_waitrequest) state_d = S_CAPT;
      end
      S_CAPT: begin
        if (!enable) abort_d = 1'b1;
        raw_d   = avm_readdata[0] ^ ACT_LOW;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        state_d = S_IDLE;
        if (enable && !abort_q) begin
          if (raw_q != pressed_q) begin
            if (stable_cnt_q == DEB_LAST) begin
              pressed_d    = raw_q;
              stable_cnt_d = 8'd0;
              if (raw_q) begin
                press_pulse_d = 1'b1;
                press_count_d = press_count_q + 16'd1;
              end
`ifdef BUTTON_POLLER_RELEASE_EVT_EN
              release_pulse_d = !raw_q;
`endif
            end else begin
              stable_cnt_d = stable_cnt_q + 8'd1;
            end
          end else begin
            stable_cnt_d = 8'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= 16'd0;
      raw_q         <= 1'b0;
      abort_q       <= 1'b0;
      pressed_q     <= 1'b0;
      press_pulse_q <= 1'b0;
      press_count_q <= 16'd0;
      stable_cnt_q  <= 8'd0;
`ifdef BUTTON_POLLER_RELEASE_EVT_EN
      release_pulse_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      raw_q         <= raw_d;
      abort_q       <= abort_d;
      pressed_q     <= pressed_d;
      press_pulse_q <= press_pulse_d;
      press_count_q <= press_count_d;
      stable_cnt_q  <= stable_cnt_d;
`ifdef BUTTON_POLLER_RELEASE_EVT_EN
      release_pulse_q <= release_pulse_d;
`endif
    end
  end

  assign avm_address = 2'b00;
  assign avm_read    = (state_q == S_REQ);
  assign pressed     = pressed_q;
  assign press_pulse = press_pulse_q;
  assign press_count = press_count_q;
`ifdef BUTTON_POLLER_RELEASE_EVT_EN
  assign release_pulse = release_pulse_q;
`endif

endmodule

// File: tb/tb_main_button_poller.sv
// Testbench for main_button_poller: a slave process answers reads with
// queued or random button levels and pushes the reference model's expected
// outputs into a scoreboard; a monitor pops and compares them three cycles
// after each accepted read.
module tb_main_button_poller;

  localparam int POLL_DIV   = 8;
  localparam int DEB        = 4;
  localparam int ACTIVE_LOW = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        pressed;
  logic        press_pulse;
  logic [15:0] press_count;
  logic        release_pulse;

  main_button_poller #(
    .POLL_DIV(POLL_DIV), .DEBOUNCE_CNT(DEB), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .pressed(pressed), .press_pulse(press_pulse),
`ifdef BUTTON_POLLER_RELEASE_EVT_EN
    .press_count(press_count), .release_pulse(release_pulse)
`else
    .press_count(press_count)
`endif
  );
`ifndef BUTTON_POLLER_RELEASE_EVT_EN
  assign release_pulse = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic        p;
    logic        pp;
    logic [15:0] cnt;
    logic        rp;
  } exp_t;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  logic bits_q[$];
  logic idle_bit = 1'b1;
  logic sl_busy = 1'b0;
  int   pend = 0;
  int   seen_press = 0;
  int   seen_rel = 0;

  // reference model: debounced level flips once the last DEB valid samples
  // all disagree with it; the sample history restarts after every flip
  logic        m_pressed = 1'b0;
  logic        m_hist[$];
  logic [15:0] m_count = 16'd0;
  int          m_npress = 0;
  int          m_nrel = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    $display("FAIL %s: got timeout, required DUT event", name);
  endtask

  task automatic model_step(input logic b, input logic valid, output exp_t e);
    logic raw;
    logic all_diff;
    e.pp = 1'b0;
    e.rp = 1'b0;
    if (valid) begin
      raw = (ACTIVE_LOW != 0) ? ~b : b;
      m_hist.push_back(raw);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      if (m_hist.size() == DEB) begin
        all_diff = 1'b1;
        foreach (m_hist[i]) if (m_hist[i] == m_pressed) all_diff = 1'b0;
        if (all_diff) begin
          m_pressed = raw;
          m_hist.delete();
          if (raw) begin
            m_count++;
            m_npress++;
            e.pp = 1'b1;
          end else begin
            m_nrel++;
            e.rp = 1'b1;
          end
        end
      end
    end
    e.p   = m_pressed;
    e.cnt = m_count;
  endtask

  // slave + stimulus source: answers each accepted read one cycle later
  initial begin : slave
    logic        en_ok;
    logic        b;
    logic [31:0] r;
    exp_t        e;
    en_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        en_ok = 1'b1;
      end else if (avm_read) begin
        en_ok &= enable;
        if (!avm_waitrequest) begin
          sl_busy = 1'b1;
          b = (bits_q.size() > 0) ? bits_q.pop_front() : idle_bit;
          @(posedge clk);
          #1 r = $urandom(); avm_readdata = {r[31:1], b};
          @(negedge clk);
          en_ok &= enable;
          @(posedge clk);
          #1 r = $urandom(); avm_readdata = {r[31:1], ~b};
          @(negedge clk);
          en_ok &= enable;
          model_step(b, en_ok, e);
          exp_q.push_back(e);
          en_ok = 1'b1;
          sl_busy = 1'b0;
        end
      end
    end
  end

  // monitor: pops the scoreboard three cycles after acceptance
  initial begin : monitor
    exp_t e;
    logic last_p;
    logic prev_pulse;
    last_p = 1'b0;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0;
        last_p = 1'b0;
        prev_pulse = 1'b0;
      end else begin
        if (press_pulse || release_pulse) begin
          if (press_pulse) seen_press++;
          if (release_pulse) seen_rel++;
          check("pulse_isolated", 32'({press_pulse && release_pulse, prev_pulse}), 0);
        end
        prev_pulse = press_pulse || release_pulse;
        if (pend > 0) begin
          pend--;
          if (pend == 1) begin
            check("early_pressed", 32'(pressed), 32'(last_p));
            check("early_pulse", 32'(press_pulse), 0);
          end else if (pend == 0) begin
            if (exp_q.size() == 0) begin
              note_fail("scoreboard_empty");
            end else begin
              e = exp_q.pop_front();
              check("sb_pressed", 32'(pressed), 32'(e.p));
              check("sb_press_pulse", 32'(press_pulse), 32'(e.pp));
              check("sb_press_count", 32'(press_count), 32'(e.cnt));
`ifdef BUTTON_POLLER_RELEASE_EVT_EN
              check("sb_release_pulse", 32'(release_pulse), 32'(e.rp));
`endif
              last_p = e.p;
            end
          end
        end
        if (avm_read && !avm_waitrequest) begin
          check("avm_address", 32'(avm_address), 0);
          pend = 3;
        end
      end
    end
  end

  task automatic push_n(input logic b, input int n);
    repeat (n) bits_q.push_back(b);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bits_q.size() == 0 && !sl_busy && exp_q.size() == 0 && pend == 0) return;
    end
    note_fail("drain_timeout");
  endtask

  // negedges until avm_read rises; -1 on timeout
  task automatic wait_rise(output int n);
    logic last;
    last = avm_read;
    for (int i = 1; i <= 500; i++) begin
      @(negedge clk);
      if (avm_read && !last) begin
        n = i;
        return;
      end
      last = avm_read;
    end
    n = -1;
    note_fail("avm_read_timeout");
  endtask

  initial begin : stim
    int n, hi, base, base_rel;
    logic found;
    logic b;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_avm_read", 32'(avm_read), 0);
    check("rst_avm_address", 32'(avm_address), 0);
    check("rst_pressed", 32'(pressed), 0);
    check("rst_press_pulse", 32'(press_pulse), 0);
    check("rst_press_count", 32'(press_count), 0);
    check("rst_release_pulse", 32'(release_pulse), 0);
    @(posedge clk);
    #1 reset = 1'b0; enable = 1'b1;

    // idle polling: first poll after POLL_DIV dwell, then every POLL_DIV+3
    wait_rise(n);
    check("first_poll", n, POLL_DIV + 1);
    for (int k = 0; k < 3; k++) begin
      wait_rise(n);
      check("idle_period", n, POLL_DIV + 3);
    end
    check("idle_no_press", seen_press, 0);
    check("idle_count", 32'(press_count), 0);

    // clean press
    base = seen_press;
    push_n(1'b0, 10);
    drain();
    check("clean_pulses", seen_press - base, 1);
    check("clean_count", 32'(press_count), 1);
    check("clean_pressed", 32'(pressed), 1);
    push_n(1'b1, 4);
    drain();
    check("clean_released", 32'(pressed), 0);

    // bounce rejection then a late valid press
    base = seen_press;
    for (int k = 0; k < 20; k++) bits_q.push_back(k[0]);
    drain();
    check("bounce_pulses", seen_press - base, 0);
    check("bounce_count", 32'(press_count), 1);
    push_n(1'b0, 3);
    push_n(1'b1, 1);
    push_n(1'b0, 4);
    drain();
    check("bounce_late_pulses", seen_press - base, 1);
    check("bounce_late_count", 32'(press_count), 2);
    push_n(1'b1, 4);
    drain();

    // random runs
    for (int k = 0; k < 14; k++) begin
      b = 1'($urandom_range(0, 1));
      push_n(b, $urandom_range(1, 7));
    end
    drain();
    push_n(1'b1, 4);
    drain();

    // waitrequest stall of 5 cycles
    wait_rise(n);
    @(posedge clk);
    #1 avm_waitrequest = 1'b1;
    bits_q.push_back(1'($urandom_range(0, 1)));
    wait_rise(n);
    hi = 1;
    for (int i = 0; i < 50; i++) begin
      if (i == 4) begin
        @(posedge clk);
        #1 avm_waitrequest = 1'b0;
      end
      @(negedge clk);
      if (avm_read) hi++;
      else break;
    end
    check("stall_read_cycles", hi, 6);
    wait_rise(n);
    check("stall_period", hi + n, POLL_DIV + 8);
    push_n(1'b1, 4);
    drain();

    // enable drop during a stalled read: sample discarded
    push_n(1'b0, 4);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bits_q.size() <= 1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) note_fail("queue_wait_timeout");
    @(posedge clk);
    #1 avm_waitrequest = 1'b1;
    wait_rise(n);
    base = seen_press;
    @(posedge clk);
    #1 enable = 1'b0;
    hi = 1;
    for (int i = 0; i < 50; i++) begin
      if (i == 2) begin
        @(posedge clk);
        #1 avm_waitrequest = 1'b0;
      end
      @(negedge clk);
      if (avm_read) hi++;
      else break;
    end
    check("drop_read_held", hi, 4);
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (avm_read) hi++;
    end
    check("drop_no_poll", hi, 0);
    check("drop_no_press", seen_press - base, 0);
    check("drop_pressed", 32'(pressed), 0);
    bits_q.push_back(1'b0);
    @(posedge clk);
    #1 enable = 1'b1;
    wait_rise(n);
    check("reenable_first_poll", n, POLL_DIV + 1);
    drain();
    check("reenable_press", seen_press - base, 1);
    push_n(1'b1, 4);
    drain();

    // counter wrap, then release
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (10) @(negedge clk);
    force dut.press_count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    @(negedge clk);
    release dut.press_count_q;
    repeat (2) @(negedge clk);
    check("preload_count", 32'(press_count), 32'h0000FFFF);
    base = seen_press;
    base_rel = seen_rel;
    push_n(1'b0, 4);
    @(posedge clk);
    #1 enable = 1'b1;
    drain();
    check("wrap_count", 32'(press_count), 0);
    check("wrap_pulses", seen_press - base, 1);
    push_n(1'b1, 4);
    drain();
    check("release_count", 32'(press_count), 0);
    check("release_pressed", 32'(pressed), 0);
    check("release_no_press", seen_press - base, 1);
`ifdef BUTTON_POLLER_RELEASE_EVT_EN
    check("release_pulses", seen_rel - base_rel, 1);
`endif

    // reset in the middle of a stalled read
    push_n(1'b0, 4);
    drain();
    check("pre_reset_count", 32'(press_count), 1);
    wait_rise(n);
    @(posedge clk);
    #1 avm_waitrequest = 1'b1;
    wait_rise(n);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("read_before_reset", 32'(avm_read), 1);
    @(negedge clk);
    check("read_after_reset", 32'(avm_read), 0);
    check("reset_pressed", 32'(pressed), 0);
    check("reset_count", 32'(press_count), 0);
    m_pressed = 1'b0;
    m_hist.delete();
    m_count = 16'd0;
    @(posedge clk);
    #1 reset = 1'b0; avm_waitrequest = 1'b0;
    push_n(1'b0, 4);
    drain();
    check("post_reset_count", 32'(press_count), 1);

    check("total_press_pulses", seen_press, m_npress);
`ifdef BUTTON_POLLER_RELEASE_EVT_EN
    check("total_release_pulses", seen_rel, m_nrel);
`endif
    check("scoreboard_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
